// File: rtl/serial_aes_host.sv
// Host-side master for the 2-wire serial AES link: uploads pt/key bit-serially,
// waits for the target's trig pulse, then captures the returned ciphertext.
module serial_aes_host #(
    parameter int RX_DELAY = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] pt,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [127:0] ct,
    output logic         s,
    output logic         k,
    input  logic         c,
    input  logic         trig
);
    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    DLY_LAST   = 4'(RX_DELAY - 1);
    localparam logic [6:0]    IDX_LAST   = 7'd127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HS,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DLY,
        ST_RECV,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [6:0]    r_idx;
    logic [6:0]    w_idx_nxt;
    logic [6:0]    w_idx_inc;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [3:0]    r_dly;
    logic [3:0]    w_dly_nxt;

    logic          r_s;
    logic          r_k;
    logic          r_busy;
    logic          r_done;
    logic          r_timeout;
    logic          w_s_nxt;
    logic          w_k_nxt;
    logic          w_done_nxt;
    logic          w_timeout_nxt;
    logic          w_load;
    logic          w_sample;

    logic [127:0]  r_pt_sh;
    logic [127:0]  r_key_sh;
    logic [126:0]  r_ct_sh;
    logic [127:0]  r_ct;
    logic [127:0]  w_ct_final;

    assign w_idx_inc = r_idx + 7'd1;

    // Samples arrive MSB first, so after 127 shifts the first one sits in bit 126
    // and the final sample, taken straight from c, completes the word.
    assign w_ct_final = {r_ct_sh, c};

    assign s       = r_s;
    assign k       = r_k;
    assign busy    = r_busy;
    assign done    = r_done;
    assign timeout = r_timeout;
    assign ct      = r_ct;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_timer_nxt   = r_timer;
        w_dly_nxt     = r_dly;
        w_s_nxt       = 1'b0;
        w_k_nxt       = 1'b0;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        w_load        = 1'b0;
        w_sample      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HS;
                    w_s_nxt     = 1'b1;
                    w_k_nxt     = 1'b1;
                end
            end
            ST_HS: begin
                w_state_nxt = ST_SEND;
                w_idx_nxt   = 7'd0;
                w_s_nxt     = r_pt_sh[0];
                w_k_nxt     = r_key_sh[0];
            end
            ST_SEND: begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_WAIT_HI;
                    w_timer_nxt = '0;
                end else begin
                    w_idx_nxt = w_idx_inc;
                    w_s_nxt   = r_pt_sh[w_idx_inc];
                    w_k_nxt   = r_key_sh[w_idx_inc];
                end
            end
            ST_WAIT_HI: begin
                if (trig) begin
                    w_state_nxt = ST_WAIT_LO;
                    w_timer_nxt = '0;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!trig) begin
                    w_state_nxt = ST_DLY;
                    w_dly_nxt   = 4'd0;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_DLY: begin
                if (r_dly == DLY_LAST) begin
                    w_state_nxt = ST_RECV;
                    w_idx_nxt   = IDX_LAST;
                end else begin
                    w_dly_nxt = r_dly + 4'd1;
                end
            end
            ST_RECV: begin
                w_sample = 1'b1;
                if (r_idx == 7'd0) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt = r_idx - 7'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= 7'd0;
            r_timer   <= '0;
            r_dly     <= 4'd0;
            r_s       <= 1'b0;
            r_k       <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_ct      <= '0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_timer   <= w_timer_nxt;
            r_dly     <= w_dly_nxt;
            r_s       <= w_s_nxt;
            r_k       <= w_k_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_done_nxt) begin
                r_ct <= w_ct_final;
            end
        end
    end

    // NOTE: the shift registers carry no reset; they are always reloaded or fully
    // refilled before any of their bits reach an output.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_pt_sh  <= pt;
            r_key_sh <= key;
        end
        if (w_sample) begin
            r_ct_sh <= {r_ct_sh[125:0], c};
        end
    end

endmodule

// File: tb/tb_serial_aes_host.sv
// Self-checking bench for serial_aes_host: a cycle-schedule target model drives
// trig/c and predicts framing, pulses, latency and captured ciphertext.
module tb_serial_aes_host;
    localparam int RX = 3;
    localparam int TO = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] pt;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         timeout;
    logic [127:0] ct;
    logic         s;
    logic         k;
    logic         c;
    logic         trig;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] model_ct;

    always #5 clk = ~clk;

    serial_aes_host #(.RX_DELAY(RX), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pt      (pt),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .ct      (ct),
        .s       (s),
        .k       (k),
        .c       (c),
        .trig    (trig)
    );

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ret;
        int           hi_delay;
        int           hi_len;
        bit           hold;
        bit           exp_to;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Cycle t counts from the start cycle. Last data bit is on the wire in t=129,
    // WAIT_HI begins at t=130; trig is high for t in [129+hi_delay, +hi_len).
    function automatic void plan(input int hd, input int hl, output bit to,
                                 output int t_to, output int t_done);
        int on_t, off_t, x;
        on_t   = 129 + hd;
        off_t  = on_t + hl;
        x      = (on_t > 130) ? on_t : 130;
        to     = 1'b0;
        t_to   = 0;
        t_done = off_t + RX + 129;
        if (x >= 130 + TO) begin
            to   = 1'b1;
            t_to = 130 + TO;
        end else if (off_t - (x + 1) >= TO) begin
            to   = 1'b1;
            t_to = x + 1 + TO;
        end
    endfunction

    task automatic run_txn(input logic [127:0] p, input logic [127:0] kk, input logic [127:0] cr,
                           input int hd, input int hl, input bit hold, input bit exp_to,
                           input string tag);
        bit m_to;
        int t_to, t_done, t_fin, on_t, off_t, rx0;
        int sk_err, busy_err, ct_err, done_cnt, to_cnt, done_at, to_at;
        logic exp_s, exp_k, exp_busy;
        plan(hd, hl, m_to, t_to, t_done);
        t_fin    = exp_to ? t_to : t_done;
        on_t     = 129 + hd;
        off_t    = on_t + hl;
        rx0      = off_t + RX + 1;
        sk_err   = 0;
        busy_err = 0;
        ct_err   = 0;
        done_cnt = 0;
        to_cnt   = 0;
        done_at  = -1;
        to_at    = -1;
        for (int t = 0; t <= t_fin; t++) begin
            @(posedge clk);
            #1;
            rst   = 1'b0;
            start = (t == 0) || hold;
            pt    = (t == 0) ? p : ~p;
            key   = (t == 0) ? kk : ~kk;
            trig  = (t >= on_t) && (t < off_t);
            if (!exp_to && t >= rx0 && t < rx0 + 128) c = cr[127 - (t - rx0)];
            else c = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_s    = (t == 1) ? 1'b1 : ((t >= 2 && t <= 129) ? p[t - 2] : 1'b0);
            exp_k    = (t == 1) ? 1'b1 : ((t >= 2 && t <= 129) ? kk[t - 2] : 1'b0);
            exp_busy = (t >= 1) && (exp_to ? (t < t_to) : (t <= t_done));
            if (s !== exp_s || k !== exp_k) sk_err++;
            if (busy !== exp_busy) busy_err++;
            if (done === 1'b1) begin done_cnt++; done_at = t; end
            if (timeout === 1'b1) begin to_cnt++; to_at = t; end
            if (t < t_fin && ct !== model_ct) ct_err++;
        end
        check($sformatf("%s.sk_frame_errs", tag), 128'(sk_err), 128'(0));
        check($sformatf("%s.busy_errs", tag), 128'(busy_err), 128'(0));
        check($sformatf("%s.ct_hold_errs", tag), 128'(ct_err), 128'(0));
        check($sformatf("%s.done_pulses", tag), 128'(done_cnt), exp_to ? 128'(0) : 128'(1));
        check($sformatf("%s.timeout_pulses", tag), 128'(to_cnt), exp_to ? 128'(1) : 128'(0));
        check($sformatf("%s.end_cycle", tag), 128'(exp_to ? to_at : done_at), 128'(t_fin));
        check($sformatf("%s.ct", tag), ct, exp_to ? model_ct : cr);
        if (!exp_to) model_ct = cr;
    endtask

    task automatic idle(input int n, input string tag);
        int err;
        err = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            trig  = 1'b0;
            c     = 1'($urandom_range(0, 1));
            @(negedge clk);
            if ({s, k, busy, done, timeout} !== 5'b0 || ct !== model_ct) err++;
        end
        check(tag, 128'(err), 128'(0));
    endtask

    task automatic reset_mid_send();
        logic [127:0] p;
        int err;
        p   = rand128();
        err = 0;
        for (int t = 0; t <= 62; t++) begin
            @(posedge clk);
            #1;
            start = (t == 0);
            pt    = p;
            key   = ~p;
            trig  = 1'b0;
            rst   = (t == 62);
            @(negedge clk);
        end
        check("rst_mid.s_at_idx60", {s, k}, {p[60], ~p[60]});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid.outputs_after", {s, k, busy, done, timeout}, 5'b0);
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            trig = (t >= 20 && t < 30);
            c    = 1'($urandom_range(0, 1));
            @(negedge clk);
            if ({s, k, busy, done, timeout} !== 5'b0) err++;
        end
        check("rst_mid.quiet_after", 128'(err), 128'(0));
        check("rst_mid.ct_cleared", ct, 128'(0));
        model_ct = '0;
        run_txn(rand128(), rand128(), rand128(), 4, 6, 1'b0, 1'b0, "rst_mid.clean");
        idle(3, "rst_mid.idle");
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                     128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 10, 1'b0, 1'b0};
        vecs[1]  = '{{128{1'b1}}, 128'h0, 128'h0123456789abcdeffedcba9876543210, 0, 2, 1'b0, 1'b0};
        vecs[2]  = '{128'h1, 128'h0, {1'b1, 127'b0}, 5, 1, 1'b0, 1'b0};
        vecs[3]  = '{128'hcafe, 128'hbeef, 128'h5555, TO + 50, 5, 1'b0, 1'b1};
        vecs[4]  = '{128'ha5a5, 128'h5a5a, 128'hf00dface, TO, 4, 1'b0, 1'b0};
        vecs[5]  = '{128'h1234, 128'h4321, 128'h7777, TO + 1, 4, 1'b0, 1'b1};
        vecs[6]  = '{128'h9999, 128'h8888, 128'h3333, 2, TO + 1, 1'b0, 1'b1};
        vecs[7]  = '{128'hdead, 128'hbeef, 128'habcdef, 2, TO, 1'b0, 1'b0};
        vecs[8]  = '{rand128(), rand128(), rand128(), 1, 3, 1'b1, 1'b0};
        vecs[9]  = '{rand128(), rand128(), rand128(), 4, 1, 1'b1, 1'b0};
        vecs[10] = '{rand128(), rand128(), rand128(), 0, 7, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b1;
        pt    = rand128();
        key   = rand128();
        c     = 1'b1;
        trig  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.outputs", {s, k, busy, done, timeout}, 5'b0);
        check("reset.ct", ct, 128'(0));
        model_ct = '0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        trig  = 1'b0;
        @(negedge clk);
        check("reset.release_idle", {s, k, busy}, 3'b0);

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].pt, vecs[i].key, vecs[i].ret, vecs[i].hi_delay, vecs[i].hi_len,
                    vecs[i].hold, vecs[i].exp_to, $sformatf("vec%0d", i));
            if (!vecs[i].hold) idle(3, $sformatf("vec%0d.idle", i));
        end

        reset_mid_send();

        for (int i = 0; i < 12; i++) begin
            int hd, hl, t_to, t_done;
            bit to;
            hd = $urandom_range(0, 20);
            hl = $urandom_range(2, 30);
            plan(hd, hl, to, t_to, t_done);
            run_txn(rand128(), rand128(), rand128(), hd, hl, 1'b0, to, $sformatf("rand%0d", i));
            idle(1 + (i % 3), $sformatf("rand%0d.idle", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
